// File: rtl/mem_pkg.sv
// Shared state encoding and SRAM geometry for the MEM-stage SRAM controller.
package mem_pkg;

  localparam int          SRAM_ADDR_W         = 18;
  localparam int          SRAM_DATA_W         = 16;
  localparam logic [31:0] ADDR_OFFSET_DEFAULT = 32'd1024;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller turning one 32-bit load/store into two 16-bit SRAM
// half-accesses; ready low freezes the pipeline while an access is in flight.
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_OFFSET = ADDR_OFFSET_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ALU_result,
  input  logic [31:0]            Val_Rm,
  output logic [31:0]            Mem_read_value,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
  input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in,
  output logic                   SRAM_DQ_oe,
  output logic                   SRAM_WE_N
);

  localparam int              CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t               state;
  logic [CNT_W-1:0]         wait_cnt;
  logic [SRAM_DATA_W-1:0]   rd_lo;
  logic                     last_cycle;
  logic [31:0]              rel_addr;
  logic [SRAM_ADDR_W-2:0]   word_addr;
  logic                     unused_addr_bits;

  assign last_cycle       = (wait_cnt == LAST_CNT);
  assign rel_addr         = ALU_result - ADDR_OFFSET;
  assign word_addr        = rel_addr[18:2];
  // Byte offset and bits above the SRAM window are intentionally dropped.
  assign unused_addr_bits = ^{rel_addr[31:19], rel_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      rd_lo          <= '0;
      Mem_read_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (MEM_W_EN)
            state <= WR_LO;
          else if (MEM_R_EN)
            state <= RD_LO;
        end
        RD_LO, RD_HI, WR_LO, WR_HI: begin
          if (last_cycle) begin
            wait_cnt <= '0;
            case (state)
              RD_LO: begin
                rd_lo <= SRAM_DQ_in;
                state <= RD_HI;
              end
              RD_HI: begin
                Mem_read_value <= {SRAM_DQ_in, rd_lo};
                state          <= DONE;
              end
              WR_LO:   state <= WR_HI;
              default: state <= DONE;
            endcase
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // WE_N rises on the last cycle of each write phase so the address never moves under a strobe.
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    case (state)
      RD_LO: SRAM_ADDR = {word_addr, 1'b0};
      RD_HI: SRAM_ADDR = {word_addr, 1'b1};
      WR_LO: begin
        SRAM_ADDR   = {word_addr, 1'b0};
        SRAM_DQ_out = Val_Rm[15:0];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = last_cycle;
      end
      WR_HI: begin
        SRAM_ADDR   = {word_addr, 1'b1};
        SRAM_DQ_out = Val_Rm[31:16];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = last_cycle;
      end
      default: ;
    endcase
  end

  assign ready = (state == DONE) || ((state == IDLE) && !MEM_R_EN && !MEM_W_EN);

endmodule
